debug_port_arbiter: RTL and testbench

Shares the single memory-mapped debug write port of a simulation-only debug sink (UART log, scheduling, pipe, traffic and safe-record registers) among N_REQ requesters, e.g. the core, the DMNI and the task injector of one PE. Each requester gets a small FIFO with a valid/ready handshake. A round-robin arbiter issues at most one registered write per cycle. Multi-word safe records (0x50, 0x54, 0x58, then 0x5C) are locked so one requester's sequence is never interleaved with another's.

---
 rtl/debug_port_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_debug_port_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : debug_port_arbiter
// Purpose  : Shares the single write port of a simulation-only debug sink
//            among N_REQ requesters. Each requester has its own small FIFO
//            with a valid/ready handshake. A round-robin arbiter issues at
//            most one registered write per cycle. Safe-record sequences
//            (0x50/0x54/0x58 ... 0x5C) are locked to one requester so they
//            never interleave with another requester's writes.
// Macro    : DEBUG_ARB_LOCK_EN -- when defined, safe-record locking is built
//            in; when undefined, arbitration is pure per-word round-robin
//            and lock_o is tied to 0.
// Ports    : clk_i, rst_ni (async, active-low)
//            req_valid_i/req_ready_o/req_addr_i/req_data_i : per-requester push
//            dbg_en_o/dbg_we_o/dbg_addr_o/dbg_data_o       : registered write
//            dbg_src_o : requester shown on the port, lock_o : lock held
// Revision : 1.0 - initial release
// ============================================================================
module debug_port_arbiter #(
  parameter int N_REQ      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [N_REQ-1:0]           req_valid_i,
  output logic [N_REQ-1:0]           req_ready_o,
  input  logic [N_REQ-1:0][23:0]     req_addr_i,
  input  logic [N_REQ-1:0][31:0]     req_data_i,
  output logic                       dbg_en_o,
  output logic                       dbg_we_o,
  output logic [23:0]                dbg_addr_o,
  output logic [31:0]                dbg_data_o,
  output logic [$clog2(N_REQ)-1:0]   dbg_src_o,
  output logic                       lock_o
);

  localparam int SRC_W = $clog2(N_REQ);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int EW    = 24 + 32;

  logic [N_REQ-1:0] not_empty;
  logic [N_REQ-1:0] full;
  logic [N_REQ-1:0] push;
  logic [N_REQ-1:0] pop;
  logic [23:0]      head_addr [N_REQ];
  logic [31:0]      head_data [N_REQ];

  logic             grant_valid;
  logic [SRC_W-1:0] grant_idx;
  logic [SRC_W-1:0] cand;
  logic [SRC_W-1:0] rr_ptr;
  int               rr_sum;
  logic [23:0]      pop_addr;

  logic             lock_held;
  logic [SRC_W-1:0] lock_owner;

  // --------------------------------------------------------------------------
  // Per-requester FIFOs. Pointers carry one extra wrap bit so full and empty
  // are distinguishable. Ready depends only on the current occupancy, so a
  // full FIFO stays not-ready even in a cycle where it is being popped.
  // --------------------------------------------------------------------------
  generate
    for (genvar i = 0; i < N_REQ; i++) begin : g_fifo
      logic [EW-1:0] mem [FIFO_DEPTH];
      logic [AW:0]   wr_ptr;
      logic [AW:0]   rd_ptr;

      assign full[i]        = (wr_ptr[AW] != rd_ptr[AW]) &&
                              (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
      assign not_empty[i]   = (wr_ptr != rd_ptr);
      assign req_ready_o[i] = rst_ni & ~full[i];
      assign push[i]        = req_valid_i[i] & req_ready_o[i];
      assign pop[i]         = grant_valid && (grant_idx == SRC_W'(i));
      assign {head_addr[i], head_data[i]} = mem[rd_ptr[AW-1:0]];

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
        end else begin
          if (push[i]) wr_ptr <= wr_ptr + 1'b1;
          if (pop[i])  rd_ptr <= rd_ptr + 1'b1;
        end
      end

      // Storage needs no reset: entries are only read once the pointers
      // say they were written.
      always_ff @(posedge clk_i) begin
        if (push[i]) mem[wr_ptr[AW-1:0]] <= {req_addr_i[i], req_data_i[i]};
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Grant: the lock owner exclusively while locked (idle bubble if its FIFO
  // is empty), otherwise the first non-empty FIFO at or after rr_ptr.
  // --------------------------------------------------------------------------
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    rr_sum      = 0;
    if (lock_held) begin
      grant_valid = not_empty[lock_owner];
      grant_idx   = lock_owner;
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        rr_sum = int'(rr_ptr) + k;
        if (rr_sum >= N_REQ) rr_sum = rr_sum - N_REQ;
        cand = SRC_W'(rr_sum);
        if (!grant_valid && not_empty[cand]) begin
          grant_valid = 1'b1;
          grant_idx   = cand;
        end
      end
    end
  end

  assign pop_addr = head_addr[grant_idx];

  // Issue register. Address, data and source hold their last value on idle
  // cycles; only the strobe drops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dbg_en_o   <= 1'b0;
      dbg_addr_o <= '0;
      dbg_data_o <= '0;
      dbg_src_o  <= '0;
      rr_ptr     <= '0;
    end else begin
      dbg_en_o <= grant_valid;
      if (grant_valid) begin
        dbg_addr_o <= pop_addr;
        dbg_data_o <= head_data[grant_idx];
        dbg_src_o  <= grant_idx;
        rr_ptr     <= (grant_idx == SRC_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  assign dbg_we_o = dbg_en_o;

`ifdef DEBUG_ARB_LOCK_EN
  // --------------------------------------------------------------------------
  // Safe-record lock. The state register updates on the same edge that
  // registers the popped word, so lock_o rises with the opening word on the
  // port and falls with the closing 0x5C word.
  // --------------------------------------------------------------------------
  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  lock_state_e      state_q, state_d;
  logic [SRC_W-1:0] owner_q, owner_d;
  logic             open_addr;

  assign open_addr = (pop_addr == 24'h000050) || (pop_addr == 24'h000054) ||
                     (pop_addr == 24'h000058);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= UNLOCKED;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      UNLOCKED: begin
        if (grant_valid && open_addr) begin
          state_d = LOCKED;
          owner_d = grant_idx;
        end
      end
      LOCKED: begin
        // Only the owner can be granted here, so any pop is the owner's.
        if (grant_valid && (pop_addr == 24'h00005C)) state_d = UNLOCKED;
      end
    endcase
  end

  assign lock_held  = (state_q == LOCKED);
  assign lock_owner = owner_q;
  assign lock_o     = lock_held;
`else
  assign lock_held  = 1'b0;
  assign lock_owner = '0;
  assign lock_o     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_debug_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_debug_port_arbiter
// Purpose  : Self-checking bench for debug_port_arbiter (N_REQ=4,
//            FIFO_DEPTH=4). A queue-based reference model predicts every
//            output each cycle; directed tables and sequences add explicit
//            checks for reset, round-robin order, FIFO fill, the safe-record
//            lock (either build of DEBUG_ARB_LOCK_EN) and mid-sequence reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_debug_port_arbiter;

  localparam int N = 4;
  localparam int D = 4;
`ifdef DEBUG_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      valid;
  logic [N-1:0]      ready;
  logic [N-1:0][23:0] addr;
  logic [N-1:0][31:0] data;
  logic              dbg_en, dbg_we, lock;
  logic [23:0]       dbg_addr;
  logic [31:0]       dbg_data;
  logic [1:0]        dbg_src;

  debug_port_arbiter #(.N_REQ(N), .FIFO_DEPTH(D)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_valid_i(valid),
    .req_ready_o(ready),
    .req_addr_i (addr),
    .req_data_i (data),
    .dbg_en_o   (dbg_en),
    .dbg_we_o   (dbg_we),
    .dbg_addr_o (dbg_addr),
    .dbg_data_o (dbg_data),
    .dbg_src_o  (dbg_src),
    .lock_o     (lock)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed { logic [23:0] a; logic [31:0] d; } ent_t;
  ent_t        q [N][$];
  int          rr, m_owner;
  bit          m_locked;
  logic        e_en, e_lock;
  logic [23:0] e_addr;
  logic [31:0] e_data;
  logic [1:0]  e_src;
  int          m_acc [N];
  int          iss [N];

  int n_cmp = 0;
  int n_err = 0;

  // lock-window statistics, gathered from the port
  bit in_win, win_done;
  int src1_win, idle_win, lock_wr;
  logic lock_at_5c;
  int seq = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) q[i].delete();
    rr = 0; m_locked = 1'b0; m_owner = 0;
    e_en = 1'b0; e_lock = 1'b0; e_addr = '0; e_data = '0; e_src = '0;
  endtask

  function automatic bit is_open(input logic [23:0] a);
    return (a == 24'h50) || (a == 24'h54) || (a == 24'h58);
  endfunction

  // One clock edge of the arbiter, computed from the rules directly.
  task automatic model_edge();
    bit   gv;
    int   g;
    bit   acc [N];
    ent_t e;
    if (!rst_n) begin
      model_reset();
      return;
    end
    gv = 1'b0; g = 0;
    if (m_locked) begin
      gv = (q[m_owner].size() > 0);
      g  = m_owner;
    end else begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (rr + k) % N;
        if (!gv && q[idx].size() > 0) begin gv = 1'b1; g = idx; end
      end
    end
    for (int i = 0; i < N; i++) acc[i] = valid[i] && (q[i].size() < D);
    e_en = gv;
    if (gv) begin
      e = q[g].pop_front();
      e_addr = e.a; e_data = e.d; e_src = 2'(g);
      rr = (g + 1) % N;
      if (LOCK_EN) begin
        if (!m_locked && is_open(e.a)) begin m_locked = 1'b1; m_owner = g; end
        else if (m_locked && e.a == 24'h5C) m_locked = 1'b0;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        e.a = addr[i]; e.d = data[i];
        q[i].push_back(e);
        m_acc[i]++;
      end
    end
    e_lock = m_locked;
  endtask

  task automatic check_outputs();
    logic [N-1:0] er;
    for (int i = 0; i < N; i++) er[i] = rst_n && (q[i].size() < D);
    chk("dbg_en", dbg_en, e_en);
    chk("dbg_we", dbg_we, e_en);
    chk("dbg_addr", dbg_addr, e_addr);
    chk("dbg_data", dbg_data, e_data);
    chk("dbg_src", dbg_src, e_src);
    chk("lock", lock, e_lock);
    chk("ready", ready, er);
  endtask

  task automatic track();
    if (dbg_en) iss[dbg_src]++;
    if (dbg_en && dbg_src == 2'd0 && dbg_addr == 24'h50) in_win = 1'b1;
    if (in_win) begin
      if (dbg_en && dbg_src == 2'd1) src1_win++;
      if (!dbg_en) idle_win++;
      if (dbg_en && dbg_src == 2'd0 && dbg_addr == 24'h5C) begin
        in_win = 1'b0; win_done = 1'b1; lock_at_5c = lock;
      end
    end
    if (dbg_en && lock) lock_wr++;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
    track();
  endtask

  task automatic apply_reset();
    valid = '0;
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < N; i++) begin m_acc[i] = 0; iss[i] = 0; end
    in_win = 0; win_done = 0; src1_win = 0; idle_win = 0; lock_wr = 0; lock_at_5c = 1'bx;
    #1;
    check_outputs();
    step();
    step();
    rst_n = 1'b1;
    #1;
    check_outputs();
  endtask

  task automatic drive(input int i, input logic [23:0] a);
    addr[i] = a;
    data[i] = {8'(i), 24'(seq)};
    seq++;
  endtask

  typedef struct { logic [3:0] v; logic en; logic [1:0] src; bit chk_src; } vec_t;
  vec_t tbl [7];

  initial begin
    int stale;
    tbl[0] = '{4'b1011, 1'b0, 2'd0, 1'b0};
    tbl[1] = '{4'b1011, 1'b1, 2'd0, 1'b1};
    tbl[2] = '{4'b1011, 1'b1, 2'd1, 1'b1};
    tbl[3] = '{4'b1011, 1'b1, 2'd3, 1'b1};
    tbl[4] = '{4'b1011, 1'b1, 2'd0, 1'b1};
    tbl[5] = '{4'b1011, 1'b1, 2'd1, 1'b1};
    tbl[6] = '{4'b1011, 1'b1, 2'd3, 1'b1};

    rst_n = 1'b1; valid = '0; addr = '0; data = '0;
    #2;

    // ---- reset release, single push to requester 2 ----
    apply_reset();
    chk("rst_ready_all", ready, 4'hF);
    chk("rst_en", dbg_en, 1'b0);
    valid = 4'b0100; addr[2] = 24'h0; data[2] = 32'h41;
    step();
    valid = '0;
    chk("single_edge_k_en", dbg_en, 1'b0);
    step();
    chk("single_en", dbg_en, 1'b1);
    chk("single_addr", dbg_addr, 24'h0);
    chk("single_data", dbg_data, 32'h41);
    chk("single_src", dbg_src, 2'd2);
    step();
    chk("single_one_cycle", dbg_en, 1'b0);

    // ---- round-robin over requesters 0,1,3 ----
    apply_reset();
    for (int r = 0; r < 7; r++) begin
      valid = tbl[r].v;
      for (int i = 0; i < N; i++) drive(i, 24'h100 + 24'(i * 4));
      step();
      chk("rr_en", dbg_en, tbl[r].en);
      if (tbl[r].chk_src) chk("rr_src", dbg_src, tbl[r].src);
    end
    valid = '0;
    repeat (20) step();

    // ---- fill FIFO 1 while other requesters hold the grants ----
    apply_reset();
    for (int c = 0; c < 11; c++) begin
      valid = 4'b1111;
      for (int i = 0; i < N; i++) drive(i, 24'h200 + 24'(i * 4));
      step();
      if (c == 4) chk("fifo1_full_ready", ready[1], 1'b0);
    end
    valid = '0;
    repeat (30) step();
    chk("fifo1_no_loss_dup", iss[1], m_acc[1]);

    // ---- safe-record lock: req0 record with gap, req1 streaming ----
    apply_reset();
    for (int c = 0; c < 14; c++) begin
      valid[1] = 1'b1;
      drive(1, 24'h0);
      case (c)
        0: begin valid[0] = 1'b1; drive(0, 24'h50); end
        1: begin valid[0] = 1'b1; drive(0, 24'h54); end
        2: begin valid[0] = 1'b1; drive(0, 24'h58); end
        5: begin valid[0] = 1'b1; drive(0, 24'h5C); end
        default: valid[0] = 1'b0;
      endcase
      step();
    end
    valid = '0;
    repeat (20) step();
    chk("lock_window_closed", win_done, 1'b1);
    chk("lock_no_src1_in_record", src1_win == 0, LOCK_EN);
    chk("lock_gap_idle", idle_win, LOCK_EN ? 2 : 0);
    chk("lock_held_writes", lock_wr, LOCK_EN ? 3 : 0);
    chk("lock_low_at_5c", lock_at_5c, 1'b0);

    // ---- reset while requester 2 holds the lock with 2 queued ----
    apply_reset();
    valid = 4'b0111;
    drive(0, 24'h300); drive(1, 24'h304); drive(2, 24'h50);
    step();
    valid = 4'b0100; drive(2, 24'h54);
    step();
    drive(2, 24'h58);
    step();
    valid = '0;
    step();
    chk("prerst_src", dbg_src, 2'd2);
    chk("prerst_lock", lock, LOCK_EN);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    chk("midrst_en", dbg_en, 1'b0);
    chk("midrst_lock", lock, 1'b0);
    chk("midrst_ready", ready, 4'h0);
    step();
    rst_n = 1'b1;
    #1;
    check_outputs();
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (dbg_en || lock) stale++;
    end
    chk("postrst_no_stale", stale, 0);

    // ---- randomized traffic against the model ----
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        int r;
        valid[i] = ($urandom_range(0, 9) < 6);
        r = $urandom_range(0, 7);
        case (r)
          0: addr[i] = 24'h50;
          1: addr[i] = 24'h54;
          2: addr[i] = 24'h58;
          3: addr[i] = 24'h5C;
          default: addr[i] = 24'($urandom) | 24'h001000;
        endcase
        data[i] = $urandom;
      end
      step();
    end
    valid = '0;
    repeat (40) step();
    for (int i = 0; i < N; i++) chk("rand_drained", iss[i], m_acc[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
